fp_adder_arbiter: RTL

- Shares the single IEEE-754 single-precision adder (strt/busy/valid/out handshake) among NREQ requesters, e.g. the feed-forward accumulation lanes and the bias-add path.
- Round-robin grant, one operation in flight.
- Routes each result back to the requester that issued it.
- Watchdog converts a hung adder operation into a flagged qNaN response.

---
 rtl/fp_adder_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fp_adder_arbiter.sv
// ---------------------------------------------------------------------------
// fp_adder_arbiter
//
// Shares one single-precision floating-point adder among NREQ requesters.
// Requesters are served round-robin with exactly one operation in flight.
// Each result is returned to the requester that issued it. A watchdog turns
// an operation that never completes into a qNaN response and sets a sticky
// error flag.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   req          per-requester request, held with operands until gnt
//   op_a, op_b   packed operands, slice i (W bits) belongs to requester i
//   gnt          one-hot single-cycle pulse: that requester's operands taken
//   rsp_valid    one-hot single-cycle pulse: rsp_data belongs to that requester
//   rsp_data     last result, held until the next response
//   unit_in1/2   adder operands, stable for the whole operation
//   unit_strt    adder start pulse
//   unit_busy    adder busy, blocks new grants
//   unit_valid   adder result valid
//   unit_out     adder result
//   arb_busy     high while an operation is being granted, issued or awaited
//   timeout_err  sticky watchdog flag
//   op_count     number of responses delivered, wraps
// ---------------------------------------------------------------------------
module fp_adder_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 64,
    parameter int CNTW    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_data,
    output logic [W-1:0]      unit_in1,
    output logic [W-1:0]      unit_in2,
    output logic              unit_strt,
    input  logic              unit_busy,
    input  logic              unit_valid,
    input  logic [W-1:0]      unit_out,
    output logic              arb_busy,
    output logic              timeout_err,
    output logic [CNTW-1:0]   op_count
);

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = $clog2(TIMEOUT + 2);
    // Watchdog value on the last WAIT edge before the response is forced,
    // so the qNaN response lands TIMEOUT cycles after the start pulse.
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [IW:0]    NREQ_W  = (IW + 1)'(NREQ);
    localparam logic [W-1:0]   QNAN    = W'(32'h7FC0_0000);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state_reg;
    logic [IW-1:0]   last_reg;
    logic [IW-1:0]   owner_reg;
    logic [WDW-1:0]  wd_reg;

    logic [W-1:0]    op_a_arr [NREQ];
    logic [W-1:0]    op_b_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign op_a_arr[gi] = op_a[gi*W +: W];
            assign op_b_arr[gi] = op_b[gi*W +: W];
        end
    endgenerate

    // Round-robin search: last+1, last+2, ... wrapping modulo NREQ.
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW:0]     cand;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = {1'b0, last_reg} + (IW + 1)'(off);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!pick_found && req[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            last_reg    <= IW'(NREQ - 1);
            owner_reg   <= '0;
            wd_reg      <= '0;
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            unit_in1    <= '0;
            unit_in2    <= '0;
            unit_strt   <= 1'b0;
            arb_busy    <= 1'b0;
            timeout_err <= 1'b0;
            op_count    <= '0;
        end else begin
            // Pulse outputs default low; the branches below raise them.
            gnt       <= '0;
            rsp_valid <= '0;
            unit_strt <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_found && !unit_busy) begin
                        unit_in1      <= op_a_arr[pick_idx];
                        unit_in2      <= op_b_arr[pick_idx];
                        gnt[pick_idx] <= 1'b1;
                        owner_reg     <= pick_idx;
                        last_reg      <= pick_idx;
                        arb_busy      <= 1'b1;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    unit_strt <= 1'b1;
                    wd_reg    <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    wd_reg <= wd_reg + WDW'(1);
                    // A genuine result takes precedence over watchdog expiry.
                    if (unit_valid) begin
                        rsp_data             <= unit_out;
                        rsp_valid[owner_reg] <= 1'b1;
                        op_count             <= op_count + CNTW'(1);
                        arb_busy             <= 1'b0;
                        state_reg            <= IDLE;
                    end else if ((TIMEOUT != 0) && (wd_reg == WD_LAST)) begin
                        rsp_data             <= QNAN;
                        rsp_valid[owner_reg] <= 1'b1;
                        timeout_err          <= 1'b1;
                        op_count             <= op_count + CNTW'(1);
                        arb_busy             <= 1'b0;
                        state_reg            <= IDLE;
                    end
                end
                default: begin
                    arb_busy  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
